iwdg_sequencer: RTL and testbench

Wishbone master that brings up and services the independent watchdog. On a start request it performs the unlock/configure/start key sequence (prescaler, reload value, start key) over the Wishbone bus. It then keeps the watchdog alive with reload-key writes, issued periodically and on demand. It sits between the system control logic and the watchdog's Wishbone slave port, so software never has to hand-sequence key writes.

---
 rtl/iwdg_sequencer_if.sv | 23 ++
 rtl/iwdg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_iwdg_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iwdg_sequencer_if.sv
// Wishbone single-write master/slave bundle between iwdg_sequencer and the watchdog slave port.
interface iwdg_sequencer_if #(
   parameter int GRL = 1
);
   logic [31:0]  adr_m2s;
   logic [31:0]  dat_m2s;
   logic [GRL:0] sel_m2s;
   logic         cyc_m2s;
   logic         stb_m2s;
   logic         we_m2s;
   logic         ack_s2m;
   logic         err_s2m;

   modport master (
      output adr_m2s, dat_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
      input  ack_s2m, err_s2m
   );

   modport slave (
      input  adr_m2s, dat_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
      output ack_s2m, err_s2m
   );
endinterface

// File: rtl/iwdg_sequencer.sv
// Watchdog key sequencer: unlock/PR/unlock/RLR/start over Wishbone, then periodic and on-demand AAAA reloads.
// Strobe rises the cycle after a trigger; one idle cycle between writes; slave stalls bounded by ACK_TIMEOUT.
module iwdg_sequencer #(
   parameter int          GRL            = 1,
   parameter logic [31:0] BASE_ADR       = 32'h0100_0000,
   parameter int          REFRESH_PERIOD = 1024,
   parameter int          ACK_TIMEOUT    = 16,
   parameter int          CNT_W          = 16
) (
   input  logic             clk_m2s,
   input  logic             rst_m2s_n,
   input  logic             cfg_start,
   input  logic [2:0]       cfg_pr,
   input  logic [11:0]      cfg_rlr,
   input  logic             kick_req,
   iwdg_sequencer_if.master wb,
   output logic             busy,
   output logic             running,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [7:0]       refresh_cnt
);
   localparam int                TW         = $clog2(ACK_TIMEOUT);
   localparam logic [TW-1:0]     TMO_LAST   = TW'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_PERIOD - 1);
   localparam logic [31:0]       KEY_UNLOCK = 32'h0000_5555;
   localparam logic [31:0]       KEY_START  = 32'h0000_CCCC;
   localparam logic [31:0]       KEY_RELOAD = 32'h0000_AAAA;

   typedef enum logic [3:0] {
      S_IDLE, S_UNL1, S_PR, S_UNL2, S_RLR, S_STRT, S_RUN, S_REFRESH, S_FAULT
   } state_t;

   state_t           state_q;
   state_t           tgt_d;
   state_t           nxt_d;
   logic             wr_q;
   logic [31:0]      adr_q;
   logic [31:0]      dat_q;
   logic [31:0]      adr_d;
   logic [31:0]      dat_d;
   logic             go_d;
   logic [TW-1:0]    tmo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             gap_q;
   logic [2:0]       pr_q;
   logic [11:0]      rlr_q;
   logic             busy_q;
   logic             running_q;
   logic             fault_q;
   logic [1:0]       code_q;
   logic [7:0]       rcnt_q;

   // tgt_d is the write the next strobe will carry; nxt_d is where its ack leads.
   always_comb begin
      tgt_d = state_q;
      if (state_q == S_IDLE || state_q == S_FAULT) tgt_d = S_UNL1;
      else if (state_q == S_RUN)                   tgt_d = S_REFRESH;
      adr_d = BASE_ADR;
      dat_d = '0;
      nxt_d = S_IDLE;
      case (tgt_d)
         S_UNL1:    begin dat_d = KEY_UNLOCK; nxt_d = S_PR; end
         S_PR:      begin adr_d = BASE_ADR + 32'h4; dat_d = {29'b0, pr_q}; nxt_d = S_UNL2; end
         S_UNL2:    begin dat_d = KEY_UNLOCK; nxt_d = S_RLR; end
         S_RLR:     begin adr_d = BASE_ADR + 32'h8; dat_d = {20'b0, rlr_q}; nxt_d = S_STRT; end
         S_STRT:    begin dat_d = KEY_START; nxt_d = S_RUN; end
         S_REFRESH: begin dat_d = KEY_RELOAD; nxt_d = S_RUN; end
         default:   begin adr_d = '0; nxt_d = S_IDLE; end
      endcase
      case (state_q)
         S_IDLE, S_FAULT: go_d = cfg_start;
         S_RUN:           go_d = kick_req || (!gap_q && cnt_q == CNT_LAST);
         default:         go_d = !wr_q;
      endcase
   end

   always_ff @(posedge clk_m2s or negedge rst_m2s_n) begin
      if (!rst_m2s_n) begin
         state_q   <= S_IDLE;
         wr_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         tmo_q     <= '0;
         cnt_q     <= '0;
         gap_q     <= 1'b0;
         pr_q      <= '0;
         rlr_q     <= '0;
         busy_q    <= 1'b0;
         running_q <= 1'b0;
         fault_q   <= 1'b0;
         code_q    <= 2'b00;
         rcnt_q    <= '0;
      end else begin
         if (go_d) begin
            wr_q    <= 1'b1;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tmo_q   <= '0;
            state_q <= tgt_d;
            busy_q  <= 1'b1;
         end
         case (state_q)
            S_IDLE, S_FAULT: begin
               if (cfg_start) begin
                  pr_q    <= cfg_pr;
                  rlr_q   <= cfg_rlr;
                  fault_q <= 1'b0;
                  code_q  <= 2'b00;
               end
            end
            S_RUN: begin
               // The cycle right after a reload ack is the inter-write gap and is not counted.
               if (!go_d) begin
                  if (gap_q) gap_q <= 1'b0;
                  else       cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               if (wr_q) begin
                  if (wb.err_s2m || (!wb.ack_s2m && tmo_q == TMO_LAST)) begin
                     wr_q      <= 1'b0;
                     adr_q     <= '0;
                     dat_q     <= '0;
                     state_q   <= S_FAULT;
                     busy_q    <= 1'b0;
                     running_q <= 1'b0;
                     fault_q   <= 1'b1;
                     code_q    <= wb.err_s2m ? 2'b10 : 2'b01;
                  end else if (wb.ack_s2m) begin
                     wr_q    <= 1'b0;
                     adr_q   <= '0;
                     dat_q   <= '0;
                     state_q <= nxt_d;
                     if (nxt_d == S_RUN) begin
                        busy_q <= 1'b0;
                        cnt_q  <= '0;
                        gap_q  <= 1'b1;
                     end
                     if (state_q == S_STRT)    running_q <= 1'b1;
                     if (state_q == S_REFRESH) rcnt_q    <= rcnt_q + 8'd1;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign wb.adr_m2s  = adr_q;
   assign wb.dat_m2s  = dat_q;
   assign wb.sel_m2s  = {(GRL + 1){1'b1}};
   assign wb.cyc_m2s  = wr_q;
   assign wb.stb_m2s  = wr_q;
   assign wb.we_m2s   = wr_q;
   assign busy        = busy_q;
   assign running     = running_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign refresh_cnt = rcnt_q;
endmodule

// File: tb/tb_iwdg_sequencer.sv
// Directed bench for iwdg_sequencer: bring-up, periodic/kick refresh, timeout, slave error, async reset.
module tb_iwdg_sequencer;
   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [2:0]  cfg_pr = '0;
   logic [11:0] cfg_rlr = '0;
   logic        kick_req = 1'b0;
   logic        busy, running, fault;
   logic [1:0]  fault_code;
   logic [7:0]  refresh_cnt;

   int checks = 0;
   int failures = 0;
   int pr_wait = 0;
   bit err_rlr = 1'b0;
   int age = 0;
   int idx;
   logic [31:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic [31:0] exp_adr[5];
   logic [31:0] exp_dat[5];

   iwdg_sequencer_if #(.GRL(1)) wb();

   iwdg_sequencer #(
      .GRL(1), .BASE_ADR(BASE), .REFRESH_PERIOD(8), .ACK_TIMEOUT(16), .CNT_W(16)
   ) dut (
      .clk_m2s(clk), .rst_m2s_n(rst_n), .cfg_start(cfg_start), .cfg_pr(cfg_pr),
      .cfg_rlr(cfg_rlr), .kick_req(kick_req), .wb(wb), .busy(busy), .running(running),
      .fault(fault), .fault_code(fault_code), .refresh_cnt(refresh_cnt)
   );

   always #5 clk = ~clk;

   // Slave: PR write acked in stb cycle pr_wait (0 = zero-wait); all others zero-wait.
   always_comb begin
      wb.ack_s2m = 1'b0;
      wb.err_s2m = 1'b0;
      if (wb.stb_m2s) begin
         wb.ack_s2m = (wb.adr_m2s == BASE + 32'h4) ? (age == pr_wait) : 1'b1;
         wb.err_s2m = err_rlr && (wb.adr_m2s == BASE + 32'h8);
      end
   end

   always @(posedge clk) age <= wb.stb_m2s ? age + 1 : 0;

   always @(posedge clk) begin
      if (wb.cyc_m2s && wb.stb_m2s && (wb.ack_s2m || wb.err_s2m)) begin
         log_adr.push_back(wb.adr_m2s);
         log_dat.push_back(wb.dat_m2s);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge of cycle N+1 (N = acceptance edge).
   task automatic start(input logic [2:0] pr, input logic [11:0] rlr);
      cfg_pr = pr;
      cfg_rlr = rlr;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_adr = '{BASE, BASE + 32'h4, BASE, BASE + 32'h8, BASE};
      exp_dat = '{32'h5555, 32'h3, 32'h5555, 32'h123, 32'hCCCC};

      // Reset state
      adv(2);
      check("rst_cyc", {31'b0, wb.cyc_m2s}, 32'd0);
      check("rst_stb_we", {30'b0, wb.stb_m2s, wb.we_m2s}, 32'd0);
      check("rst_adr", wb.adr_m2s, 32'd0);
      check("rst_dat", wb.dat_m2s, 32'd0);
      check("rst_sel", {30'b0, wb.sel_m2s}, 32'd3);
      check("rst_status", {27'b0, busy, running, fault, fault_code}, 32'd0);
      check("rst_rcnt", {24'b0, refresh_cnt}, 32'd0);
      rst_n = 1'b1;
      adv(3);
      check("idle_no_bus", log_adr.size(), 32'd0);

      // Bring-up with zero-wait slave
      start(3'd3, 12'h123);
      check("b_first_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("b_first_adr", wb.adr_m2s, BASE);
      check("b_first_dat", wb.dat_m2s, 32'h5555);
      check("b_busy", {31'b0, busy}, 32'd1);
      adv(8);
      check("b_run_n9", {31'b0, running}, 32'd0);
      adv(1);
      check("b_run_n10", {31'b0, running}, 32'd1);
      check("b_busy_done", {31'b0, busy}, 32'd0);
      check("b_nwrites", log_adr.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("b_adr%0d", i), log_adr[i], exp_adr[i]);
         check($sformatf("b_dat%0d", i), log_dat[i], exp_dat[i]);
      end

      // Periodic refresh every 10 cycles
      adv(8);
      check("p1_pre", {31'b0, wb.stb_m2s}, 32'd0);
      adv(1);
      check("p1_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("p1_dat", wb.dat_m2s, 32'hAAAA);
      check("p1_adr", wb.adr_m2s, BASE);
      adv(9);
      check("p2_pre", {31'b0, wb.stb_m2s}, 32'd0);
      check("p2_rcnt", {24'b0, refresh_cnt}, 32'd1);
      adv(1);
      check("p2_stb", {31'b0, wb.stb_m2s}, 32'd1);
      adv(10);
      check("p3_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("p3_rcnt_pre", {24'b0, refresh_cnt}, 32'd2);
      adv(1);
      check("p3_rcnt", {24'b0, refresh_cnt}, 32'd3);

      // Kick coinciding with expiry, held into the refresh write
      adv(8);
      check("k_pre", {31'b0, wb.stb_m2s}, 32'd0);
      kick_req = 1'b1;
      adv(1);
      check("k_stb", {31'b0, wb.stb_m2s}, 32'd1);
      adv(1);
      kick_req = 1'b0;
      check("k_done", {31'b0, wb.stb_m2s}, 32'd0);
      check("k_rcnt", {24'b0, refresh_cnt}, 32'd4);
      idx = log_adr.size();
      adv(8);
      check("k_no_extra", log_adr.size(), idx);
      check("k_quiet", {31'b0, wb.stb_m2s}, 32'd0);
      adv(1);
      check("k_natural", {31'b0, wb.stb_m2s}, 32'd1);

      // Mid-period kick: strobe the cycle after the kick is sampled
      adv(3);
      check("mk_pre", {31'b0, wb.stb_m2s}, 32'd0);
      kick_req = 1'b1;
      adv(1);
      kick_req = 1'b0;
      check("mk_stb", {31'b0, wb.stb_m2s}, 32'd1);
      adv(1);
      check("mk_rcnt", {24'b0, refresh_cnt}, 32'd6);

      // cfg_start while running is ignored
      idx = log_adr.size();
      start(3'd7, 12'hFFF);
      check("rs_stb", {31'b0, wb.stb_m2s}, 32'd0);
      check("rs_status", {28'b0, busy, running, fault, 1'b0}, 32'd4);
      adv(2);
      check("rs_stb2", {31'b0, wb.stb_m2s}, 32'd0);
      check("rs_nlog", log_adr.size(), idx);

      // Ack timeout on PR write
      pulse_reset();
      pr_wait = 255;
      check("t_rst_rcnt", {24'b0, refresh_cnt}, 32'd0);
      check("t_rst_run", {31'b0, running}, 32'd0);
      adv(1);
      start(3'd5, 12'hABC);
      adv(1);
      check("t_gap", {31'b0, wb.stb_m2s}, 32'd0);
      adv(1);
      check("t_pr_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("t_pr_adr", wb.adr_m2s, BASE + 32'h4);
      check("t_pr_dat", wb.dat_m2s, 32'd5);
      adv(15);
      check("t_last_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("t_last_fault", {31'b0, fault}, 32'd0);
      adv(1);
      check("t_drop", {30'b0, wb.cyc_m2s, wb.stb_m2s}, 32'd0);
      check("t_fault", {31'b0, fault}, 32'd1);
      check("t_code", {30'b0, fault_code}, 32'd1);
      check("t_run_busy", {30'b0, running, busy}, 32'd0);

      // Restart from FAULT; PR acked in the last allowed stb cycle
      pr_wait = 15;
      idx = log_adr.size();
      start(3'd5, 12'hABC);
      check("r_fault_clr", {29'b0, fault, fault_code}, 32'd0);
      check("r_busy", {31'b0, busy}, 32'd1);
      adv(17);
      check("r_pr_16th", {31'b0, wb.stb_m2s}, 32'd1);
      check("r_pr_adr", wb.adr_m2s, BASE + 32'h4);
      adv(1);
      check("r_pr_ok", {30'b0, wb.stb_m2s, fault}, 32'd0);
      adv(5);
      check("r_run_pre", {31'b0, running}, 32'd0);
      adv(1);
      check("r_run", {31'b0, running}, 32'd1);
      check("r_nofault", {31'b0, fault}, 32'd0);
      check("r_nlog", log_adr.size(), idx + 5);
      check("r_pr_val", log_dat[idx + 1], 32'd5);
      check("r_rlr_val", log_dat[idx + 3], 32'hABC);

      // Slave error (with simultaneous ack) on RLR write
      pulse_reset();
      pr_wait = 0;
      err_rlr = 1'b1;
      adv(1);
      start(3'd2, 12'h7FF);
      adv(6);
      check("e_rlr_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("e_rlr_adr", wb.adr_m2s, BASE + 32'h8);
      adv(1);
      check("e_fault", {31'b0, fault}, 32'd1);
      check("e_code", {30'b0, fault_code}, 32'd2);
      check("e_bus", {31'b0, wb.stb_m2s}, 32'd0);
      check("e_run_busy", {30'b0, running, busy}, 32'd0);
      err_rlr = 1'b0;

      // Async reset while the start-key write is on the bus
      start(3'd1, 12'h010);
      adv(8);
      check("a_strt_stb", {31'b0, wb.stb_m2s}, 32'd1);
      check("a_strt_dat", wb.dat_m2s, 32'hCCCC);
      #2 rst_n = 1'b0;
      #1;
      check("a_bus_drop", {29'b0, wb.cyc_m2s, wb.stb_m2s, wb.we_m2s}, 32'd0);
      check("a_adr_dat", wb.adr_m2s | wb.dat_m2s, 32'd0);
      check("a_status", {27'b0, busy, running, fault, fault_code}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idx = log_adr.size();
      adv(5);
      check("a_quiet", {31'b0, wb.stb_m2s}, 32'd0);
      check("a_nlog", log_adr.size(), idx);
      start(3'd1, 12'h010);
      check("a_restart", {31'b0, wb.stb_m2s}, 32'd1);
      check("a_restart_dat", wb.dat_m2s, 32'h5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
